// File: rtl/ldtu_rx_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the DTU serial receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ldtu_rx_pkg;

  localparam int NBITS_DEF = 32;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } alignState_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] satInc(input logic [31:0] val, input int width);
    logic [31:0] maxVal;
    maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= maxVal) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ser_shift_match.sv
`timescale 1ns/1ps
// Serial-to-parallel window: shift register, fill counter and pattern comparator.
// Latency: nxtWord/patMatch are combinational on the bit being sampled this cycle.
// Backpressure: none; one bit is accepted on every CLK_SRL edge.
module ser_shift_match
  import ldtu_rx_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             CLK_SRL,
  input  logic             rst,
  input  logic             serialIn,
  input  logic             fillClear,
  input  logic [NBITS-1:0] synchPattern,
  output logic [NBITS-1:0] nxtWord,
  output logic             fillFull,
  output logic             patMatch
);
  localparam int FW = $clog2(NBITS);
  localparam logic [FW-1:0] FILL_MAX = FW'(NBITS - 1);

  logic [NBITS-1:0] shiftReg;
  logic [FW-1:0]    fillCnt;

  // The window as it will look after this edge: the comparator sees the full word
  // on the same cycle its last bit arrives.
  assign nxtWord  = {shiftReg[NBITS-2:0], serialIn};
  assign fillFull = (fillCnt == FILL_MAX);
  assign patMatch = (nxtWord == synchPattern);

  // Shift every cycle; count received bits until the window holds a whole word.
  always_ff @(posedge CLK_SRL or posedge rst) begin
    if (rst) begin
      shiftReg <= '0;
      fillCnt  <= '0;
    end else begin
      shiftReg <= nxtWord;
      if (fillClear)
        fillCnt <= '0;
      else if (!fillFull)
        fillCnt <= fillCnt + FW'(1);
    end
  end

endmodule

// File: rtl/ser_frame_aligner.sv
`timescale 1ns/1ps
// Per-lane DTU receive aligner: hunts the synch pattern, confirms word alignment, emits aligned words.
// Latency: word_valid rises one CLK_SRL cycle after the last bit of a word is sampled.
// Backpressure: none; the serial line cannot stall, so every aligned word is strobed once.
module ser_frame_aligner
  import ldtu_rx_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CLK_SRL,
  input  logic             rst,
  input  logic             enable,
  input  logic             realign,
  input  logic             serial_in,
  input  logic [NBITS-1:0] synch_pattern,
  output logic [NBITS-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic             is_pattern,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] lock_losses
);
  localparam int BW = $clog2(NBITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [3:0]    LOCK_N   = 4'(LOCK_COUNT);

  alignState_t      state, nextState;
  logic [BW-1:0]    bitCnt;
  logic [3:0]       matchCnt;
  logic [NBITS-1:0] nxtWord;
  logic             fillFull, patMatch, fillClear;
  logic             exitReq, atBoundary, huntHit, verifyHit;
  logic             emitWord, leaveLocked, toHunt;

  ser_shift_match #(.NBITS(NBITS)) uShift (
    .CLK_SRL      (CLK_SRL),
    .rst          (rst),
    .serialIn     (serial_in),
    .fillClear    (fillClear),
    .synchPattern (synch_pattern),
    .nxtWord      (nxtWord),
    .fillFull     (fillFull),
    .patMatch     (patMatch)
  );

  assign locked = (state == LOCKED);

  // Next-state decode; an exit request always beats a match or a word boundary.
  always_comb begin
    nextState   = state;
    exitReq     = realign || !enable;
    atBoundary  = (bitCnt == LAST_BIT);
    huntHit     = 1'b0;
    verifyHit   = 1'b0;
    emitWord    = 1'b0;
    leaveLocked = 1'b0;
    case (state)
      HUNT: begin
        // realign has no meaning here; only enable gates the hunt.
        if (enable && fillFull && patMatch) begin
          huntHit   = 1'b1;
          nextState = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (exitReq)
          nextState = HUNT;
        else if (atBoundary) begin
          if (patMatch) begin
            verifyHit = 1'b1;
            if (matchCnt + 4'd1 >= LOCK_N)
              nextState = LOCKED;
          end else
            nextState = HUNT;
        end
      end
      LOCKED: begin
        if (exitReq) begin
          leaveLocked = 1'b1;
          nextState   = HUNT;
        end else
          emitWord = atBoundary;
      end
      default: nextState = HUNT;
    endcase
    toHunt    = (state != HUNT) && (nextState == HUNT);
    // Entering HUNT restarts the fill so a fresh whole word is needed before matching.
    fillClear = toHunt || !enable;
  end

  // State register.
  always_ff @(posedge CLK_SRL or posedge rst) begin
    if (rst)
      state <= HUNT;
    else
      state <= nextState;
  end

  // Word-phase counter (anchored on the first hit) and consecutive-match counter.
  always_ff @(posedge CLK_SRL or posedge rst) begin
    if (rst) begin
      bitCnt   <= '0;
      matchCnt <= '0;
    end else if (huntHit) begin
      bitCnt   <= '0;
      matchCnt <= 4'd1;
    end else if (nextState == HUNT) begin
      bitCnt   <= '0;
      matchCnt <= '0;
    end else begin
      bitCnt <= atBoundary ? '0 : bitCnt + BW'(1);
      if (verifyHit)
        matchCnt <= matchCnt + 4'd1;
    end
  end

  // Aligned word output and saturating statistics.
  always_ff @(posedge CLK_SRL or posedge rst) begin
    if (rst) begin
      word_out    <= '0;
      word_valid  <= 1'b0;
      is_pattern  <= 1'b0;
      word_count  <= '0;
      lock_losses <= '0;
    end else begin
      word_valid <= emitWord;
      if (!enable) begin
        word_out   <= '0;
        is_pattern <= 1'b0;
      end else if (emitWord) begin
        word_out   <= nxtWord;
        is_pattern <= patMatch;
      end
      if (exitReq)
        word_count <= '0;
      else if (emitWord)
        word_count <= CNT_W'(satInc(32'(word_count), CNT_W));
      if (leaveLocked)
        lock_losses <= CNT_W'(satInc(32'(lock_losses), CNT_W));
    end
  end

endmodule

// File: tb/tb_ser_frame_aligner.sv
`timescale 1ns/1ps
// Bench for ser_frame_aligner: directed lock/data/exit sequences plus random stream vs. a frame-level model.
// Latency: outputs sampled 1 ns after each rising CLK_SRL edge.
// Backpressure: n/a.
module tb_ser_frame_aligner;
  localparam int NB  = 32;
  localparam int LCK = 4;
  localparam int CW  = 4;
  localparam logic [NB-1:0] PAT = 32'hEAAA_AAAA;

  logic          CLK_SRL = 1'b0;
  logic          rst, enable, realign, serial_in;
  logic [NB-1:0] synch_pattern, word_out;
  logic          word_valid, locked, is_pattern;
  logic [CW-1:0] word_count, lock_losses;

  ser_frame_aligner #(.NBITS(NB), .LOCK_COUNT(LCK), .CNT_W(CW)) dut (
    .CLK_SRL       (CLK_SRL),
    .rst           (rst),
    .enable        (enable),
    .realign       (realign),
    .serial_in     (serial_in),
    .synch_pattern (synch_pattern),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .locked        (locked),
    .is_pattern    (is_pattern),
    .word_count    (word_count),
    .lock_losses   (lock_losses)
  );

  always #5 CLK_SRL = ~CLK_SRL;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  int validSeen = 0;
  int enLow = 0;

  // Frame-level model: mode 0=hunting, 1=verifying, 2=locked.
  int            mBits[$];
  int            mMode, mAnchor, mMatches, mFill, eCount, eLoss;
  logic [NB-1:0] eWord;
  logic          eValid, ePat;

  typedef struct {
    logic [NB-1:0] word;
    logic          pat;
    int            cnt;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  function automatic logic [NB-1:0] windowWord();
    logic [NB-1:0] w;
    w = '0;
    foreach (mBits[i]) w = {w[NB-2:0], (mBits[i] != 0)};
    return w;
  endfunction

  task automatic modelReset();
    mBits.delete();
    mMode = 0; mAnchor = 0; mMatches = 0; mFill = 0;
    eCount = 0; eLoss = 0; eWord = '0; eValid = 1'b0; ePat = 1'b0;
  endtask

  // One received bit: the word boundary is every NB bits after the first hit.
  task automatic modelStep(input logic en, input logic re, input logic b, input logic [NB-1:0] pat);
    logic [NB-1:0] win;
    bit full, bnd, toHunt;
    full = (mFill >= NB - 1);
    mBits.push_back(int'(b));
    if (mBits.size() > NB) void'(mBits.pop_front());
    win    = windowWord();
    bnd    = (mMode != 0) && (((cyc - mAnchor) % NB) == 0);
    eValid = 1'b0;
    toHunt = 0;
    if (mMode != 0 && (!en || re)) begin
      if (mMode == 2) eLoss = sat(eLoss);
      mMode = 0; mMatches = 0; eCount = 0; toHunt = 1;
    end else if (mMode == 0) begin
      if (en && full && win == pat) begin
        mAnchor = cyc; mMatches = 1; mMode = (LCK == 1) ? 2 : 1;
      end
    end else if (mMode == 1) begin
      if (bnd) begin
        if (win == pat) begin
          mMatches++;
          if (mMatches >= LCK) mMode = 2;
        end else begin
          mMode = 0; mMatches = 0; toHunt = 1;
        end
      end
    end else if (bnd) begin
      eValid = 1'b1; eWord = win; ePat = (win == pat); eCount = sat(eCount);
    end
    if (!en) begin eWord = '0; ePat = 1'b0; end
    if (!en || toHunt) mFill = 0;
    else if (mFill < NB - 1) mFill++;
  endtask

  task automatic step(input logic b);
    logic [NB-1:0] pat;
    logic en, re;
    serial_in = b;
    pat = synch_pattern; en = enable; re = realign;
    @(posedge CLK_SRL);
    cyc++;
    modelStep(en, re, b, pat);
    #1;
    if (word_valid === 1'b1) validSeen++;
    check($sformatf("model@cyc%0d", cyc),
          {locked, word_valid, word_out, is_pattern, word_count, lock_losses},
          {(mMode == 2), eValid, eWord, ePat, CW'(eCount), CW'(eLoss)});
  endtask

  task automatic sendMsbs(input logic [NB-1:0] w, input int n);
    for (int i = NB - 1; i >= NB - n; i--) step(w[i]);
  endtask

  task automatic sendWord(input logic [NB-1:0] w);
    sendMsbs(w, NB);
  endtask

  task automatic randBit(input logic b);
    realign = ($urandom_range(0, 299) == 0);
    if (enLow > 0) enLow--;
    else if ($urandom_range(0, 599) == 0) enLow = $urandom_range(1, 40);
    enable = (enLow == 0);
    step(b);
  endtask

  initial begin
    logic [NB-1:0] pv;
    int t1;
    tbl[0]  = '{32'hDEAD_BEEF, 1'b0, 3};
    tbl[1]  = '{32'hEAAA_AAAA, 1'b1, 4};
    tbl[2]  = '{32'h0000_0000, 1'b0, 5};
    tbl[3]  = '{32'hFFFF_FFFF, 1'b0, 6};
    tbl[4]  = '{32'hEAAA_AAAB, 1'b0, 7};
    tbl[5]  = '{32'h6AAA_AAAA, 1'b0, 8};
    tbl[6]  = '{32'hEAAA_AAAA, 1'b1, 9};
    tbl[7]  = '{32'hA5A5_A5A5, 1'b0, 10};
    tbl[8]  = '{32'h0000_FFFF, 1'b0, 11};
    tbl[9]  = '{32'hEAAA_AAAA, 1'b1, 12};
    tbl[10] = '{32'h1357_9BDF, 1'b0, 13};
    tbl[11] = '{32'h2468_ACE0, 1'b0, 14};
    tbl[12] = '{32'hEAAA_AAAA, 1'b1, 15};
    tbl[13] = '{32'hCAFE_F00D, 1'b0, 15};
    tbl[14] = '{32'hEAAA_AAAA, 1'b1, 15};
    pv = PAT;

    // Reset with activity on the line.
    rst = 1'b1; enable = 1'b0; realign = 1'b0; serial_in = 1'b0;
    synch_pattern = 32'h5A5A_5A5A;
    modelReset();
    repeat (6) begin @(negedge CLK_SRL); serial_in = ~serial_in; end
    #1;
    check("reset_outs", {locked, word_valid, word_out, is_pattern, word_count, lock_losses}, 64'd0);
    @(posedge CLK_SRL); #1;
    rst = 1'b0; enable = 1'b1; serial_in = 1'b0;

    // Idle zeros never look like the pattern.
    repeat (200) step(1'b0);
    check("idle_locked", locked, 0);
    check("idle_no_valid", validSeen, 0);

    // Lock acquisition: 7 junk bits then 4 pattern copies.
    synch_pattern = PAT;
    repeat (7) step(1'b0);
    repeat (3) sendWord(PAT);
    sendMsbs(PAT, NB - 1);
    check("lock_not_early", locked, 0);
    step(pv[0]);
    check("lock_rise", locked, 1);
    check("no_valid_before_lock", validSeen, 0);

    // First data words after lock.
    sendWord(32'h1234_5678);
    check("d1", {word_valid, word_out, is_pattern}, {1'b1, 32'h1234_5678, 1'b0});
    t1 = cyc;
    sendWord(PAT);
    check("d2", {word_valid, word_out, is_pattern}, {1'b1, PAT, 1'b1});
    check("valid_spacing", cyc - t1, 32);
    check("count_2", word_count, 2);

    // Table of locked words, including word_count saturation at 15.
    for (int i = 0; i < 15; i++) begin
      sendWord(tbl[i].word);
      check($sformatf("tbl%0d", i), {word_valid, word_out, is_pattern, word_count},
            {1'b1, tbl[i].word, tbl[i].pat, CW'(tbl[i].cnt)});
    end

    // realign on the word-boundary cycle.
    sendMsbs(PAT, NB - 1);
    realign = 1'b1;
    step(pv[0]);
    realign = 1'b0;
    check("rl_no_valid", word_valid, 0);
    check("rl_unlocked", locked, 0);
    check("rl_losses", lock_losses, 1);
    check("rl_count", word_count, 0);

    // Verify failure on a corrupted third word, then a clean relock.
    validSeen = 0;
    sendWord(PAT);
    sendWord(PAT);
    sendWord(PAT ^ 32'd1);
    check("vf_unlocked", locked, 0);
    repeat (3) sendWord(PAT);
    check("vf_not_yet", locked, 0);
    check("vf_no_valid", validSeen, 0);
    sendWord(PAT);
    check("vf_relock", locked, 1);

    // Asynchronous reset mid-word.
    sendMsbs(PAT, 10);
    #2 rst = 1'b1;
    #0.001;
    check("ar_outs", {locked, word_valid, word_out, is_pattern, word_count, lock_losses}, 64'd0);
    #0.002 rst = 1'b0;
    modelReset();
    repeat (LCK - 1) sendWord(PAT);
    check("ar_not_yet", locked, 0);
    sendWord(PAT);
    check("ar_relock", locked, 1);
    check("ar_losses", lock_losses, 0);

    // Dropping enable clears the word path and counts a lock loss.
    sendWord(32'h0BAD_F00D);
    check("en_word", word_out, 32'h0BAD_F00D);
    enable = 1'b0;
    step(1'b0);
    check("en_low", {locked, word_out, is_pattern, lock_losses}, {1'b0, 32'd0, 1'b0, CW'(1)});
    enable = 1'b1;

    // Random stream: mostly patterns, some data, occasional slips, realign and enable drops.
    for (int w = 0; w < 120; w++) begin
      logic [NB-1:0] rw;
      rw = ($urandom_range(0, 9) < 6) ? PAT : NB'($urandom());
      if ($urandom_range(0, 9) == 0)
        repeat ($urandom_range(1, 5)) randBit(1'($urandom_range(0, 1)));
      for (int i = NB - 1; i >= 0; i--) randBit(rw[i]);
    end
    enable = 1'b1; realign = 1'b0;
    repeat (8) step(1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
